// File: rtl/multicycle_ctrl_pkg.sv
// Shared constants for the multicycle MIPS controller and the ALU control:
// ALU operation codes, controller state encodings and opcode/funct values.
package multicycle_ctrl_pkg;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_AND   = 4'd2;
  localparam logic [3:0] ALU_OR    = 4'd3;
  localparam logic [3:0] ALU_SLT   = 4'd4;
  localparam logic [3:0] ALU_LUI   = 4'd5;
  localparam logic [3:0] ALU_FUNCT = 4'd6;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_REX     = 4'd6,
    S_RWB     = 4'd7,
    S_BRANCH  = 4'd8,
    S_IEX     = 4'd9,
    S_IWB     = 4'd10,
    S_JUMP    = 4'd11,
    S_JREG    = 4'd12,
    S_ILLEGAL = 4'd13
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;

  localparam logic [5:0] FN_JR    = 6'h08;

  function automatic logic is_imm_alu(input logic [5:0] op);
    return (op == OP_ADDI) || (op == OP_ADDIU) || (op == OP_SLTI) ||
           (op == OP_ANDI) || (op == OP_ORI)   || (op == OP_LUI);
  endfunction

  function automatic logic imm_signed(input logic [5:0] op);
    return (op == OP_ADDI) || (op == OP_ADDIU) || (op == OP_SLTI);
  endfunction

  function automatic logic [3:0] imm_aluop(input logic [5:0] op);
    logic [3:0] res;
    case (op)
      OP_SLTI: res = ALU_SLT;
      OP_ANDI: res = ALU_AND;
      OP_ORI:  res = ALU_OR;
      OP_LUI:  res = ALU_LUI;
      default: res = ALU_ADD;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_next_state.sv
// Combinational next-state logic for the multicycle controller. DECODE uses
// the live IR fields; MEMADR uses the opcode latched during DECODE.
module ctrl_next_state
  import multicycle_ctrl_pkg::*;
(
  input  logic [3:0] state,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic [5:0] op_latched,
  input  logic       mem_ready,
  output logic [3:0] next_state
);

  state_e cur;
  state_e nxt;

  always_comb begin
    cur = state_e'(state);
    nxt = S_FETCH;
    case (cur)
      S_FETCH:  nxt = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if ((opcode == OP_LW) || (opcode == OP_SW)) begin
          nxt = S_MEMADR;
        end else if (opcode == OP_RTYPE) begin
          nxt = (funct == FN_JR) ? S_JREG : S_REX;
        end else if ((opcode == OP_BEQ) || (opcode == OP_BNE)) begin
          nxt = S_BRANCH;
        end else if (is_imm_alu(opcode)) begin
          nxt = S_IEX;
        end else if ((opcode == OP_J) || (opcode == OP_JAL)) begin
          nxt = S_JUMP;
        end else begin
          nxt = S_ILLEGAL;
        end
      end
      S_MEMADR: nxt = (op_latched == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  nxt = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:  nxt = mem_ready ? S_FETCH : S_MEMWR;
      S_REX:    nxt = S_RWB;
      S_IEX:    nxt = S_IWB;
      default:  nxt = S_FETCH;
    endcase
    next_state = nxt;
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS sequencing controller: state register, opcode latch and
// per-state datapath control decode.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int unsigned STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               mem_ready,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic               BranchNE,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic [1:0]         RegDst,
  output logic [1:0]         MemtoReg,
  output logic               RegWrite,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [3:0]         ALUOp,
  output logic               SignExtend,
  output logic [1:0]         PCSource,
  output logic               illegal_op,
  output logic               retire,
  output logic [STATE_W-1:0] state
);

  state_e     state_q, state_d;
  logic [3:0] ns_raw;
  logic [5:0] op_q, op_d;

  ctrl_next_state u_next_state (
    .state      (state_q),
    .opcode     (opcode),
    .funct      (funct),
    .op_latched (op_q),
    .mem_ready  (mem_ready),
    .next_state (ns_raw)
  );

  // funct is consumed only in DECODE, so only the opcode needs a held copy.
  always_comb begin
    state_d = state_e'(ns_raw);
    op_d    = (state_q == S_DECODE) ? opcode : op_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  // Gating with rst_n drops every strobe the moment reset asserts.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    BranchNE    = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    RegDst      = 2'd0;
    MemtoReg    = 2'd0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'd0;
    ALUOp       = ALU_ADD;
    SignExtend  = 1'b0;
    PCSource    = 2'd0;
    illegal_op  = 1'b0;
    retire      = 1'b0;
    state       = '0;
    if (rst_n) begin
      state = STATE_W'(state_q);
      case (state_q)
        S_FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = 2'd1;
          ALUOp   = ALU_ADD;
          if (mem_ready) begin
            IRWrite = 1'b1;
            PCWrite = 1'b1;
          end
        end
        S_DECODE: begin
          ALUSrcB    = 2'd3;
          SignExtend = 1'b1;
          ALUOp      = ALU_ADD;
        end
        S_MEMADR: begin
          ALUSrcA    = 1'b1;
          ALUSrcB    = 2'd2;
          SignExtend = 1'b1;
          ALUOp      = ALU_ADD;
        end
        S_MEMRD: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
        end
        S_MEMWB: begin
          RegWrite = 1'b1;
          MemtoReg = 2'd1;
          retire   = 1'b1;
        end
        S_MEMWR: begin
          MemWrite = 1'b1;
          IorD     = 1'b1;
          retire   = mem_ready;
        end
        S_REX: begin
          ALUSrcA = 1'b1;
          ALUOp   = ALU_FUNCT;
        end
        S_RWB: begin
          RegWrite = 1'b1;
          RegDst   = 2'd1;
          retire   = 1'b1;
        end
        S_BRANCH: begin
          ALUSrcA     = 1'b1;
          ALUOp       = ALU_SUB;
          PCWriteCond = 1'b1;
          PCSource    = 2'd1;
          BranchNE    = (op_q == OP_BNE);
          retire      = 1'b1;
        end
        S_IEX: begin
          ALUSrcA    = 1'b1;
          ALUSrcB    = 2'd2;
          ALUOp      = imm_aluop(op_q);
          SignExtend = imm_signed(op_q);
        end
        S_IWB: begin
          RegWrite = 1'b1;
          retire   = 1'b1;
        end
        S_JUMP: begin
          PCWrite  = 1'b1;
          PCSource = 2'd2;
          retire   = 1'b1;
          if (op_q == OP_JAL) begin
            RegWrite = 1'b1;
            RegDst   = 2'd2;
            MemtoReg = 2'd2;
          end
        end
        S_JREG: begin
          PCWrite  = 1'b1;
          PCSource = 2'd3;
          retire   = 1'b1;
        end
        S_ILLEGAL: begin
          illegal_op = 1'b1;
          retire     = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: an instruction-level model expands
// each instruction into its expected per-cycle control vectors.
module tb_multicycle_ctrl;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, pcwc, bne, iord, mrd, mwr, irw;
    logic [1:0] regdst, m2r;
    logic       rw, asa;
    logic [1:0] asb;
    logic [3:0] aluop;
    logic       sext;
    logic [1:0] pcsrc;
    logic       ill, ret;
  } ovec_t;

  typedef struct {
    ovec_t      e;
    logic       rdy;
    logic [5:0] op;
    logic [5:0] fn;
  } cyc_t;

  localparam logic [3:0] A_ADD = 4'd0, A_SUB = 4'd1, A_AND = 4'd2, A_OR = 4'd3,
                         A_SLT = 4'd4, A_LUI = 4'd5, A_FUNCT = 4'd6;

  logic clk = 1'b0;
  logic rst_n;
  logic [5:0] opcode, funct;
  logic mem_ready;
  logic PCWrite, PCWriteCond, BranchNE, IorD, MemRead, MemWrite, IRWrite;
  logic [1:0] RegDst, MemtoReg, ALUSrcB, PCSource;
  logic RegWrite, ALUSrcA, SignExtend, illegal_op, retire;
  logic [3:0] ALUOp;
  logic [3:0] state;

  multicycle_ctrl #(.STATE_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .BranchNE(BranchNE), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .SignExtend(SignExtend), .PCSource(PCSource),
    .illegal_op(illegal_op), .retire(retire), .state(state)
  );

  always #5 clk = ~clk;

  ovec_t act, exp_v;
  logic  exp_valid;
  int    ntests = 0, nfail = 0, nretire = 0, ncyc = 0;
  cyc_t  sched[$];

  always_comb act = {state, PCWrite, PCWriteCond, BranchNE, IorD, MemRead, MemWrite,
                     IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
                     SignExtend, PCSource, illegal_op, retire};

  // Single per-cycle compare against the model's expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_valid) begin
        ncyc++;
        ntests++;
        if (act !== exp_v) begin
          nfail++;
          $display("FAIL cycle%0d state=%0d act=%h req=%h", ncyc, state, act, exp_v);
        end
        if (retire === 1'b1) nretire++;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] a, input logic [31:0] r);
    ntests++;
    if (a !== r) begin
      nfail++;
      $display("FAIL %s act=%0h req=%0h", name, a, r);
    end
  endtask

  // rm: 0/1 = mem_ready forced to that value, 2 = don't care (randomised)
  task automatic push(input ovec_t e, input int rm, input logic [5:0] op,
                      input logic [5:0] fn, input bit real_ir);
    cyc_t c;
    c.e   = e;
    c.rdy = (rm == 2) ? 1'($urandom_range(1, 0)) : (rm == 1);
    c.op  = real_ir ? op : 6'($urandom);
    c.fn  = real_ir ? fn : 6'($urandom);
    sched.push_back(c);
  endtask

  // Instruction-level model: fetch (fw stall cycles), decode, then class tail.
  task automatic plan(input logic [5:0] op, input logic [5:0] fn,
                      input int unsigned fw, input int unsigned mw);
    ovec_t e;
    for (int unsigned i = 0; i <= fw; i++) begin
      e = '0; e.st = 4'd0; e.mrd = 1; e.asb = 2'd1; e.aluop = A_ADD;
      if (i == fw) begin e.irw = 1; e.pcw = 1; end
      push(e, (i == fw) ? 1 : 0, op, fn, 1'b0);
    end
    e = '0; e.st = 4'd1; e.asb = 2'd3; e.sext = 1; e.aluop = A_ADD;
    push(e, 2, op, fn, 1'b1);
    if (op == 6'h23 || op == 6'h2B) begin
      e = '0; e.st = 4'd2; e.asa = 1; e.asb = 2'd2; e.sext = 1; e.aluop = A_ADD;
      push(e, 2, op, fn, 1'b0);
      for (int unsigned i = 0; i <= mw; i++) begin
        e = '0; e.iord = 1;
        if (op == 6'h23) begin e.st = 4'd3; e.mrd = 1; end
        else begin e.st = 4'd5; e.mwr = 1; e.ret = (i == mw); end
        push(e, (i == mw) ? 1 : 0, op, fn, 1'b0);
      end
      if (op == 6'h23) begin
        e = '0; e.st = 4'd4; e.rw = 1; e.m2r = 2'd1; e.ret = 1;
        push(e, 2, op, fn, 1'b0);
      end
    end else if (op == 6'h00 && fn == 6'h08) begin
      e = '0; e.st = 4'd12; e.pcw = 1; e.pcsrc = 2'd3; e.ret = 1;
      push(e, 2, op, fn, 1'b0);
    end else if (op == 6'h00) begin
      e = '0; e.st = 4'd6; e.asa = 1; e.aluop = A_FUNCT;
      push(e, 2, op, fn, 1'b0);
      e = '0; e.st = 4'd7; e.rw = 1; e.regdst = 2'd1; e.ret = 1;
      push(e, 2, op, fn, 1'b0);
    end else if (op == 6'h04 || op == 6'h05) begin
      e = '0; e.st = 4'd8; e.asa = 1; e.aluop = A_SUB; e.pcwc = 1; e.pcsrc = 2'd1;
      e.bne = (op == 6'h05); e.ret = 1;
      push(e, 2, op, fn, 1'b0);
    end else if (op inside {6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0F}) begin
      e = '0; e.st = 4'd9; e.asa = 1; e.asb = 2'd2;
      e.aluop = (op == 6'h0A) ? A_SLT : (op == 6'h0C) ? A_AND :
                (op == 6'h0D) ? A_OR  : (op == 6'h0F) ? A_LUI : A_ADD;
      e.sext = (op == 6'h08 || op == 6'h09 || op == 6'h0A);
      push(e, 2, op, fn, 1'b0);
      e = '0; e.st = 4'd10; e.rw = 1; e.ret = 1;
      push(e, 2, op, fn, 1'b0);
    end else if (op == 6'h02 || op == 6'h03) begin
      e = '0; e.st = 4'd11; e.pcw = 1; e.pcsrc = 2'd2; e.ret = 1;
      if (op == 6'h03) begin e.rw = 1; e.regdst = 2'd2; e.m2r = 2'd2; end
      push(e, 2, op, fn, 1'b0);
    end else begin
      e = '0; e.st = 4'd13; e.ill = 1; e.ret = 1;
      push(e, 2, op, fn, 1'b0);
    end
  endtask

  task automatic run_n(input int n);
    cyc_t c;
    for (int i = 0; i < n && sched.size() > 0; i++) begin
      c = sched.pop_front();
      @(posedge clk);
      #1;
      rst_n     = 1'b1;
      mem_ready = c.rdy;
      opcode    = c.op;
      funct     = c.fn;
      exp_v     = c.e;
      exp_valid = 1'b1;
    end
  endtask

  task automatic run_all();
    run_n(sched.size());
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; mem_ready = 1'b0; opcode = '0; funct = '0;
    exp_v = '0; exp_valid = 1'b1;
    repeat (3) @(posedge clk);

    plan(6'h23, 6'h00, 0, 0);   // lw: states 0,1,2,3,4
    plan(6'h2B, 6'h00, 0, 2);   // sw, two not-ready cycles in MEMWR
    plan(6'h00, 6'h20, 0, 0);   // add
    plan(6'h08, 6'h00, 0, 0);
    plan(6'h09, 6'h00, 0, 0);
    plan(6'h0A, 6'h00, 0, 0);
    plan(6'h0C, 6'h00, 0, 0);
    plan(6'h0D, 6'h00, 0, 0);
    plan(6'h0F, 6'h00, 0, 0);
    plan(6'h04, 6'h00, 0, 0);   // beq
    plan(6'h05, 6'h00, 0, 0);   // bne
    plan(6'h02, 6'h00, 0, 0);   // j
    plan(6'h03, 6'h00, 0, 0);   // jal
    plan(6'h00, 6'h08, 0, 0);   // jr
    plan(6'h3F, 6'h00, 0, 0);   // illegal
    plan(6'h01, 6'h00, 0, 0);   // illegal
    plan(6'h23, 6'h00, 2, 3);   // lw with fetch and memory stalls
    plan(6'h2B, 6'h00, 1, 0);   // sw with a fetch stall
    run_all();

    // Reset while sw is stalled in MEMWR
    plan(6'h2B, 6'h00, 0, 5);
    run_n(5);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    exp_valid = 1'b0;
    #1;
    chk("memwr_reset_memwrite", 32'(MemWrite), 32'd0);
    chk("memwr_reset_retire", 32'(retire), 32'd0);
    chk("memwr_reset_state", 32'(state), 32'd0);
    exp_v = '0;
    exp_valid = 1'b1;
    repeat (2) @(posedge clk);
    sched.delete();

    plan(6'h23, 6'h00, 0, 0);
    run_all();
    @(posedge clk);
    #1;
    exp_valid = 1'b0;

    // 18 instructions before the aborted sw, 1 after it
    chk("retire_count", 32'(nretire), 32'd19);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
